prim_assembly: RTL and testbench
================================

PRIM_ASSEMBLY -- requirements
Module: prim_assembly

Interface
REQ-001 Parameter: CNT_WIDTH, 16, width of the accepted-triangle counter.
REQ-002 Port: I_CLOCK  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: I_RESET  in  1  synchronous, active-high reset.
REQ-004 Port: I_LOCK  in  1  vertex-stage output valid; an input is consumed on a rising edge with I_LOCK=1 and O_STALL=0.
REQ-005 Port: I_Opcode  in  `OPCODE_WIDTH  opcode from the vertex stage.
REQ-006 Port: I_VOut  in  `VREG_WIDTH  transformed vertex; x=[31:16], y=[47:32], signed 16-bit, 7 fractional bits.
REQ-007 Port: I_ColorOut  in  `VREG_WIDTH  colour from the vertex stage, valid with `OP_SETCOLOR.
REQ-008 Port: I_RAST_READY  in  1  downstream rasterizer can accept a triangle.
REQ-009 Port: O_STALL  out  1  drives the vertex stage's I_FRAMESTALL.
REQ-010 Port: O_TRI_VALID  out  1  triangle on O_V0/O_V1/O_V2/O_Color is valid.
REQ-011 Port: O_V0, O_V1, O_V2  out  32 each  triangle vertices packed {y,x}.
REQ-012 Port: O_Color  out  `VREG_WIDTH  triangle colour.
REQ-013 Port: O_TRI_COUNT  out  CNT_WIDTH  triangles accepted downstream; wraps modulo 2^CNT_WIDTH.
REQ-014 Port: O_DROP_COUNT  out  8  partial primitives discarded; saturates at 255.

Function
REQ-015 O_STALL SHALL be combinational: O_TRI_VALID && !I_RAST_READY.
REQ-016 A triangle SHALL be accepted on a rising edge with O_TRI_VALID=1 and I_RAST_READY=1.
REQ-017 States SHALL be IDLE (outside a primitive) and COLLECT (inside a primitive), with a 2-bit vertex count vcnt.
REQ-018 On `OP_BEGINPRIMITIVE in any state, the block SHALL enter COLLECT with vcnt=0; any partial vertices are discarded without incrementing O_DROP_COUNT.
REQ-019 On `OP_ENDPRIMITIVE, the block SHALL enter IDLE; if vcnt was 1 or 2 and no triangle of the primitive has yet formed, O_DROP_COUNT SHALL increment.
REQ-020 On `OP_SETCOLOR in any state, the colour register SHALL load I_ColorOut; triangles already formed keep their latched colour.
REQ-021 On `OP_SETVERTEX in IDLE, the input SHALL be consumed and ignored.
REQ-022 On `OP_SETVERTEX in COLLECT, the vertex SHALL be stored in slot vcnt; on the third vertex, O_V0..O_V2 and O_Color SHALL be registered and O_TRI_VALID SHALL be set.
REQ-023 Latency: a third vertex consumed at edge N SHALL present O_TRI_VALID=1 immediately after edge N.
REQ-024 Simultaneous acceptance and completion at the same edge: O_TRI_VALID SHALL stay 1 with the new data; O_TRI_COUNT SHALL increment once.
REQ-025 Acceptance without a new completion: O_TRI_VALID SHALL clear after that edge.
REQ-026 While O_TRI_VALID=1, the outputs O_V0..O_V2 and O_Color SHALL hold stable until acceptance.
REQ-027 All other opcodes SHALL be consumed with no effect.
REQ-028 A primitive ending while a triangle is pending SHALL NOT cancel that triangle.

Reset
REQ-029 While I_RESET=1 at a rising edge: state=IDLE, vcnt=0, O_TRI_VALID=0, O_V0..O_V2=0, O_Color=0, colour register=0, O_TRI_COUNT=0, O_DROP_COUNT=0.
REQ-030 Reset mid-primitive or with a pending triangle SHALL discard all work; O_STALL=0 in the cycle following reset.

Configuration
REQ-031 The macro PA_STRIP_EN SHALL select the primitive mode.
REQ-032 With PA_STRIP_EN defined (triangle strip): after the first triangle, each further vertex SHALL form a triangle from the previous two vertices plus the new one, with order (v[n-2], v[n-1], v[n]).
REQ-033 Without PA_STRIP_EN (triangle list): vcnt SHALL reset to 0 after each triangle, and every three vertices form an independent triangle.

Verification
REQ-034 Scenario (list): BEGIN, SETCOLOR 0x00FF, SETVERTEX (1,2),(3,4),(5,6), RAST_READY=1 -> one O_TRI_VALID pulse, O_V0=0x00020001, O_V1=0x00040003, O_V2=0x00060005, O_Color=0x00FF, O_TRI_COUNT=1.
REQ-035 Scenario (backpressure): complete a triangle with RAST_READY=0 for 4 cycles -> O_STALL=1 for 4 cycles, outputs stable, the next SETVERTEX is not consumed until READY=1.
REQ-036 Scenario (partial primitive): BEGIN, 2×SETVERTEX, END -> no O_TRI_VALID, O_DROP_COUNT=1; 256 such primitives -> O_DROP_COUNT=255.
REQ-037 Scenario (strip, PA_STRIP_EN): 5 vertices A..E with READY=1 -> triangles ABC, BCD, CDE on consecutive completions; O_TRI_COUNT=3.
REQ-038 Scenario (reset): I_RESET=1 with O_TRI_VALID=1 and vcnt=2 -> all outputs 0 the next cycle; a new BEGIN plus 3 vertices yields a triangle made only of the new vertices.
REQ-039 Scenario (counter wrap): CNT_WIDTH=4, 16 accepted triangles -> O_TRI_COUNT=0.

Source files
------------

// File: rtl/prim_assembly.sv
// Primitive assembly: collects SETVERTEX inputs into triangles and hands them to the rasterizer.
// Define PA_STRIP_EN for triangle-strip assembly; otherwise every three vertices form a triangle.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 4
`endif
`ifndef VREG_WIDTH
`define VREG_WIDTH 64
`endif
`ifndef OP_BEGINPRIMITIVE
`define OP_BEGINPRIMITIVE 1
`endif
`ifndef OP_ENDPRIMITIVE
`define OP_ENDPRIMITIVE 2
`endif
`ifndef OP_SETCOLOR
`define OP_SETCOLOR 3
`endif
`ifndef OP_SETVERTEX
`define OP_SETVERTEX 4
`endif

module prim_assembly #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                     I_CLOCK,
    input  logic                     I_RESET,
    input  logic                     I_LOCK,
    input  logic [`OPCODE_WIDTH-1:0] I_Opcode,
    input  logic [`VREG_WIDTH-1:0]   I_VOut,
    input  logic [`VREG_WIDTH-1:0]   I_ColorOut,
    input  logic                     I_RAST_READY,
    output logic                     O_STALL,
    output logic                     O_TRI_VALID,
    output logic [31:0]              O_V0,
    output logic [31:0]              O_V1,
    output logic [31:0]              O_V2,
    output logic [`VREG_WIDTH-1:0]   O_Color,
    output logic [CNT_WIDTH-1:0]     O_TRI_COUNT,
    output logic [7:0]               O_DROP_COUNT
);

    localparam logic [`OPCODE_WIDTH-1:0] OP_BEGIN  = `OPCODE_WIDTH'(`OP_BEGINPRIMITIVE);
    localparam logic [`OPCODE_WIDTH-1:0] OP_END    = `OPCODE_WIDTH'(`OP_ENDPRIMITIVE);
    localparam logic [`OPCODE_WIDTH-1:0] OP_COLOR  = `OPCODE_WIDTH'(`OP_SETCOLOR);
    localparam logic [`OPCODE_WIDTH-1:0] OP_VERTEX = `OPCODE_WIDTH'(`OP_SETVERTEX);

    typedef enum logic {
        S_IDLE,
        S_COLLECT
    } state_t;

    state_t                   r_state;
    logic [1:0]               r_vcnt;
    logic                     r_formed;
    logic [31:0]              r_slot0;
    logic [31:0]              r_slot1;
    logic [`VREG_WIDTH-1:0]   r_color;

    logic                     w_consume;
    logic                     w_accept;
    logic                     w_complete;
    logic signed [15:0]       w_vx;
    logic signed [15:0]       w_vy;
    logic [31:0]              w_vertex;
    logic                     w_unused;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A pending triangle blocks the vertex stage only while the rasterizer is busy.
    assign O_STALL    = O_TRI_VALID && !I_RAST_READY;
    assign w_consume  = I_LOCK && !O_STALL;
    assign w_accept   = O_TRI_VALID && I_RAST_READY;
    assign w_complete = w_consume && (I_Opcode == OP_VERTEX) &&
                        (r_state == S_COLLECT) && (r_vcnt == 2'd2);

    assign w_vx     = I_VOut[31:16];
    assign w_vy     = I_VOut[47:32];
    assign w_vertex = {w_vy, w_vx};
    assign w_unused = ^{I_VOut[`VREG_WIDTH-1:48], I_VOut[15:0]};

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            r_state      <= S_IDLE;
            r_vcnt       <= 2'd0;
            r_formed     <= 1'b0;
            r_slot0      <= '0;
            r_slot1      <= '0;
            r_color      <= '0;
            O_TRI_VALID  <= 1'b0;
            O_V0         <= '0;
            O_V1         <= '0;
            O_V2         <= '0;
            O_Color      <= '0;
            O_TRI_COUNT  <= '0;
            O_DROP_COUNT <= '0;
        end else begin
            if (w_accept)
                O_TRI_COUNT <= O_TRI_COUNT + CNT_WIDTH'(1);

            // A completion on the accepting edge keeps valid high with fresh data.
            if (w_complete)
                O_TRI_VALID <= 1'b1;
            else if (w_accept)
                O_TRI_VALID <= 1'b0;

            if (w_consume) begin
                case (I_Opcode)
                    OP_BEGIN: begin
                        r_state  <= S_COLLECT;
                        r_vcnt   <= 2'd0;
                        r_formed <= 1'b0;
                    end
                    OP_END: begin
                        r_state <= S_IDLE;
                        r_vcnt  <= 2'd0;
                        if (r_state == S_COLLECT && r_vcnt != 2'd0 && !r_formed)
                            O_DROP_COUNT <= sat_inc8(O_DROP_COUNT);
                    end
                    OP_COLOR: r_color <= I_ColorOut;
                    OP_VERTEX: begin
                        if (r_state == S_COLLECT) begin
                            case (r_vcnt)
                                2'd0: begin
                                    r_slot0 <= w_vertex;
                                    r_vcnt  <= 2'd1;
                                end
                                2'd1: begin
                                    r_slot1 <= w_vertex;
                                    r_vcnt  <= 2'd2;
                                end
                                default: begin
                                    O_V0     <= r_slot0;
                                    O_V1     <= r_slot1;
                                    O_V2     <= w_vertex;
                                    O_Color  <= r_color;
                                    r_formed <= 1'b1;
`ifdef PA_STRIP_EN
                                    r_slot0  <= r_slot1;
                                    r_slot1  <= w_vertex;
                                    r_vcnt   <= 2'd2;
`else
                                    r_vcnt   <= 2'd0;
`endif
                                end
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prim_assembly.sv
// Directed bench for prim_assembly; a second instance with CNT_WIDTH=4 shares stimulus to exercise counter wrap.
`ifndef OP_BEGINPRIMITIVE
`define OP_BEGINPRIMITIVE 1
`endif
`ifndef OP_ENDPRIMITIVE
`define OP_ENDPRIMITIVE 2
`endif
`ifndef OP_SETCOLOR
`define OP_SETCOLOR 3
`endif
`ifndef OP_SETVERTEX
`define OP_SETVERTEX 4
`endif

module tb_prim_assembly;

    localparam logic [3:0] OP_BEGIN  = 4'(`OP_BEGINPRIMITIVE);
    localparam logic [3:0] OP_END    = 4'(`OP_ENDPRIMITIVE);
    localparam logic [3:0] OP_COLOR  = 4'(`OP_SETCOLOR);
    localparam logic [3:0] OP_VERTEX = 4'(`OP_SETVERTEX);
    localparam logic [3:0] OP_NOP    = 4'hF;

    logic        clk = 1'b0;
    logic        rst;
    logic        lock;
    logic [3:0]  op;
    logic [63:0] vout;
    logic [63:0] cin;
    logic        ready;

    logic        stall, tvalid;
    logic [31:0] v0, v1, v2;
    logic [63:0] color;
    logic [15:0] tcount;
    logic [7:0]  dcount;

    logic        stall4, tvalid4;
    logic [31:0] v04, v14, v24;
    logic [63:0] color4;
    logic [3:0]  tcount4;
    logic [7:0]  dcount4;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    prim_assembly u_dut (
        .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock), .I_Opcode(op),
        .I_VOut(vout), .I_ColorOut(cin), .I_RAST_READY(ready),
        .O_STALL(stall), .O_TRI_VALID(tvalid), .O_V0(v0), .O_V1(v1), .O_V2(v2),
        .O_Color(color), .O_TRI_COUNT(tcount), .O_DROP_COUNT(dcount)
    );

    prim_assembly #(.CNT_WIDTH(4)) u_dut4 (
        .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock), .I_Opcode(op),
        .I_VOut(vout), .I_ColorOut(cin), .I_RAST_READY(ready),
        .O_STALL(stall4), .O_TRI_VALID(tvalid4), .O_V0(v04), .O_V1(v14), .O_V2(v24),
        .O_Color(color4), .O_TRI_COUNT(tcount4), .O_DROP_COUNT(dcount4)
    );

    function automatic logic [63:0] vtx(input logic [15:0] x, input logic [15:0] y);
        return {16'h0000, y, x, 16'h0000};
    endfunction

    function automatic logic [31:0] pk(input logic [15:0] x, input logic [15:0] y);
        return {y, x};
    endfunction

    task automatic issue(input logic [3:0] o, input logic [63:0] d);
        lock = 1'b1; op = o; vout = d; cin = d;
        @(posedge clk); #1;
        lock = 1'b0; op = OP_NOP;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; lock = 1'b0; op = OP_NOP; vout = '0; cin = '0; ready = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        n_vec++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", tvalid); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_vec++; if (tcount !== 16'd0 || tcount4 !== 4'd0) begin n_err++; $display("FAIL reset_tcount: got %0d/%0d want 0", tcount, tcount4); end
        n_vec++; if (dcount !== 8'd0) begin n_err++; $display("FAIL reset_dcount: got %0d want 0", dcount); end
        n_vec++; if ({v0, v1, v2, color} !== '0) begin n_err++; $display("FAIL reset_data: got %h %h %h %h want 0", v0, v1, v2, color); end
        exp_cnt = 0;
    endtask

    task automatic test_list();
        ready = 1'b1;
        issue(OP_BEGIN, '0);
        issue(OP_COLOR, 64'h00FF);
        issue(OP_VERTEX, vtx(1, 2));
        issue(OP_VERTEX, vtx(3, 4));
        n_vec++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL list_early_valid: got %b want 0", tvalid); end
        issue(OP_VERTEX, vtx(5, 6));
        n_vec++; if (tvalid !== 1'b1) begin n_err++; $display("FAIL list_valid: got %b want 1", tvalid); end
        n_vec++; if (v0 !== 32'h00020001 || v1 !== 32'h00040003 || v2 !== 32'h00060005) begin n_err++; $display("FAIL list_verts: got %h %h %h want 00020001 00040003 00060005", v0, v1, v2); end
        n_vec++; if (color !== 64'h00FF) begin n_err++; $display("FAIL list_color: got %h want 00ff", color); end
        idle_cycle();
        exp_cnt++;
        n_vec++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL list_pulse: got %b want 0", tvalid); end
        n_vec++; if (tcount !== 16'(exp_cnt)) begin n_err++; $display("FAIL list_count: got %0d want %0d", tcount, exp_cnt); end
`ifndef PA_STRIP_EN
        issue(OP_COLOR, 64'h0022);
        issue(OP_VERTEX, vtx(7, 8));
        issue(OP_VERTEX, vtx(9, 10));
        issue(OP_VERTEX, vtx(11, 12));
        n_vec++; if (tvalid !== 1'b1 || v0 !== pk(7, 8) || v1 !== pk(9, 10) || v2 !== pk(11, 12)) begin n_err++; $display("FAIL list_second: got %b %h %h %h want 1 %h %h %h", tvalid, v0, v1, v2, pk(7, 8), pk(9, 10), pk(11, 12)); end
        n_vec++; if (color !== 64'h0022) begin n_err++; $display("FAIL list_second_color: got %h want 0022", color); end
        idle_cycle();
        exp_cnt++;
`endif
        issue(OP_END, '0);
        n_vec++; if (dcount !== 8'd0) begin n_err++; $display("FAIL list_no_drop: got %0d want 0", dcount); end
        n_vec++; if (tcount !== 16'(exp_cnt)) begin n_err++; $display("FAIL list_count2: got %0d want %0d", tcount, exp_cnt); end
    endtask

    task automatic test_backpressure();
        ready = 1'b1;
        issue(OP_BEGIN, '0);
        issue(OP_COLOR, 64'h1234);
        ready = 1'b0;
        issue(OP_VERTEX, vtx(10, 20));
        issue(OP_VERTEX, vtx(30, 40));
        issue(OP_VERTEX, vtx(50, 60));
        lock = 1'b1; op = OP_VERTEX; vout = vtx(70, 80); cin = vout;
        #1;
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL bp_stall_0: got %b want 1", stall); end
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            n_vec++; if (stall !== 1'b1 || tvalid !== 1'b1) begin n_err++; $display("FAIL bp_stall_%0d: got stall=%b valid=%b want 1 1", i, stall, tvalid); end
            n_vec++; if (v0 !== pk(10, 20) || v1 !== pk(30, 40) || v2 !== pk(50, 60) || color !== 64'h1234) begin n_err++; $display("FAIL bp_hold_%0d: got %h %h %h %h", i, v0, v1, v2, color); end
        end
        ready = 1'b1;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b want 0", stall); end
        @(posedge clk); #1;
        lock = 1'b0; op = OP_NOP;
        exp_cnt++;
        n_vec++; if (tcount !== 16'(exp_cnt)) begin n_err++; $display("FAIL bp_count: got %0d want %0d", tcount, exp_cnt); end
`ifdef PA_STRIP_EN
        n_vec++; if (tvalid !== 1'b1 || v0 !== pk(30, 40) || v1 !== pk(50, 60) || v2 !== pk(70, 80)) begin n_err++; $display("FAIL bp_overlap: got %b %h %h %h", tvalid, v0, v1, v2); end
        issue(OP_VERTEX, vtx(90, 100));
        issue(OP_VERTEX, vtx(110, 120));
        exp_cnt += 2;
        n_vec++; if (tvalid !== 1'b1 || v0 !== pk(70, 80) || v1 !== pk(90, 100) || v2 !== pk(110, 120)) begin n_err++; $display("FAIL bp_next: got %b %h %h %h", tvalid, v0, v1, v2); end
`else
        n_vec++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL bp_clear: got %b want 0", tvalid); end
        issue(OP_VERTEX, vtx(90, 100));
        issue(OP_VERTEX, vtx(110, 120));
        n_vec++; if (tvalid !== 1'b1 || v0 !== pk(70, 80) || v1 !== pk(90, 100) || v2 !== pk(110, 120)) begin n_err++; $display("FAIL bp_next: got %b %h %h %h", tvalid, v0, v1, v2); end
`endif
        n_vec++; if (color !== 64'h1234) begin n_err++; $display("FAIL bp_next_color: got %h want 1234", color); end
        issue(OP_END, '0);
        exp_cnt++;
        n_vec++; if (tvalid !== 1'b0 || tcount !== 16'(exp_cnt)) begin n_err++; $display("FAIL bp_end_accept: got valid=%b count=%0d want 0 %0d", tvalid, tcount, exp_cnt); end
    endtask

    task automatic test_partial();
        ready = 1'b1;
        issue(OP_BEGIN, '0);
        issue(OP_VERTEX, vtx(1, 1));
        issue(OP_VERTEX, vtx(2, 2));
        issue(OP_END, '0);
        n_vec++; if (tvalid !== 1'b0 || dcount !== 8'd1) begin n_err++; $display("FAIL partial_first: got valid=%b drop=%0d want 0 1", tvalid, dcount); end
        issue(OP_BEGIN, '0);
        issue(OP_VERTEX, vtx(3, 3));
        issue(OP_BEGIN, '0);
        issue(OP_END, '0);
        n_vec++; if (dcount !== 8'd1) begin n_err++; $display("FAIL partial_rebegin: got %0d want 1", dcount); end
        issue(OP_BEGIN, '0);
        issue(OP_VERTEX, vtx(4, 4));
        issue(OP_NOP, '0);
        issue(OP_END, '0);
        n_vec++; if (dcount !== 8'd2) begin n_err++; $display("FAIL partial_one: got %0d want 2", dcount); end
        for (int k = 0; k < 253; k++) begin
            issue(OP_BEGIN, '0);
            issue(OP_VERTEX, vtx(5, 5));
            issue(OP_VERTEX, vtx(6, 6));
            issue(OP_END, '0);
        end
        n_vec++; if (dcount !== 8'd255) begin n_err++; $display("FAIL partial_255: got %0d want 255", dcount); end
        issue(OP_BEGIN, '0);
        issue(OP_VERTEX, vtx(5, 5));
        issue(OP_END, '0);
        n_vec++; if (dcount !== 8'd255 || tcount !== 16'(exp_cnt)) begin n_err++; $display("FAIL partial_sat: got drop=%0d count=%0d want 255 %0d", dcount, tcount, exp_cnt); end
    endtask

    task automatic test_idle_ignore();
        issue(OP_VERTEX, vtx(1, 1));
        issue(OP_VERTEX, vtx(2, 2));
        issue(OP_VERTEX, vtx(3, 3));
        issue(OP_VERTEX, vtx(4, 4));
        n_vec++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL idle_vertex: got %b want 0", tvalid); end
    endtask

    task automatic test_reset_midstream();
        ready = 1'b1;
        issue(OP_BEGIN, '0);
        issue(OP_COLOR, 64'h0ABC);
        ready = 1'b0;
        issue(OP_VERTEX, vtx(21, 22));
        issue(OP_VERTEX, vtx(23, 24));
        issue(OP_VERTEX, vtx(25, 26));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if (tvalid !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL rst_mid_ctrl: got valid=%b stall=%b want 0 0", tvalid, stall); end
        n_vec++; if ({v0, v1, v2, color} !== '0 || tcount !== 16'd0 || dcount !== 8'd0) begin n_err++; $display("FAIL rst_mid_data: got %h %h %h %h cnt=%0d drop=%0d", v0, v1, v2, color, tcount, dcount); end
        exp_cnt = 0;
        ready = 1'b1;
        issue(OP_BEGIN, '0);
        issue(OP_VERTEX, vtx(31, 32));
        issue(OP_VERTEX, vtx(33, 34));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        issue(OP_VERTEX, vtx(1, 9));
        issue(OP_VERTEX, vtx(2, 9));
        issue(OP_VERTEX, vtx(3, 9));
        n_vec++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL rst_idle: got %b want 0", tvalid); end
        issue(OP_BEGIN, '0);
        issue(OP_VERTEX, vtx(41, 42));
        issue(OP_VERTEX, vtx(43, 44));
        issue(OP_VERTEX, vtx(45, 46));
        n_vec++; if (tvalid !== 1'b1 || v0 !== pk(41, 42) || v1 !== pk(43, 44) || v2 !== pk(45, 46)) begin n_err++; $display("FAIL rst_fresh: got %b %h %h %h", tvalid, v0, v1, v2); end
        n_vec++; if (color !== 64'h0) begin n_err++; $display("FAIL rst_color: got %h want 0", color); end
        issue(OP_END, '0);
        exp_cnt++;
        n_vec++; if (tcount !== 16'(exp_cnt) || dcount !== 8'd0) begin n_err++; $display("FAIL rst_after_count: got %0d/%0d want %0d/0", tcount, dcount, exp_cnt); end
    endtask

`ifdef PA_STRIP_EN
    task automatic test_strip();
        ready = 1'b1;
        issue(OP_BEGIN, '0);
        issue(OP_VERTEX, vtx(1, 1));
        issue(OP_VERTEX, vtx(2, 2));
        issue(OP_VERTEX, vtx(3, 3));
        n_vec++; if (tvalid !== 1'b1 || v0 !== pk(1, 1) || v1 !== pk(2, 2) || v2 !== pk(3, 3)) begin n_err++; $display("FAIL strip_abc: got %b %h %h %h", tvalid, v0, v1, v2); end
        issue(OP_VERTEX, vtx(4, 4));
        n_vec++; if (tvalid !== 1'b1 || v0 !== pk(2, 2) || v1 !== pk(3, 3) || v2 !== pk(4, 4)) begin n_err++; $display("FAIL strip_bcd: got %b %h %h %h", tvalid, v0, v1, v2); end
        issue(OP_VERTEX, vtx(5, 5));
        n_vec++; if (tvalid !== 1'b1 || v0 !== pk(3, 3) || v1 !== pk(4, 4) || v2 !== pk(5, 5)) begin n_err++; $display("FAIL strip_cde: got %b %h %h %h", tvalid, v0, v1, v2); end
        issue(OP_END, '0);
        exp_cnt += 3;
        n_vec++; if (tvalid !== 1'b0 || tcount !== 16'(exp_cnt)) begin n_err++; $display("FAIL strip_count: got valid=%b count=%0d want 0 %0d", tvalid, tcount, exp_cnt); end
    endtask
`endif

    task automatic test_wrap();
        int nv;
        int base4;
`ifdef PA_STRIP_EN
        nv = 18;
`else
        nv = 48;
`endif
        base4 = exp_cnt % 16;
        n_vec++; if (tcount4 !== 4'(base4)) begin n_err++; $display("FAIL wrap_start: got %0d want %0d", tcount4, base4); end
        ready = 1'b1;
        issue(OP_BEGIN, '0);
        for (int k = 0; k < nv; k++)
            issue(OP_VERTEX, vtx(16'(k), 16'(k + 100)));
        issue(OP_END, '0);
        exp_cnt += 16;
        n_vec++; if (tcount4 !== 4'(base4)) begin n_err++; $display("FAIL wrap_4bit: got %0d want %0d", tcount4, base4); end
        n_vec++; if (tcount !== 16'(exp_cnt)) begin n_err++; $display("FAIL wrap_16bit: got %0d want %0d", tcount, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_list();
        test_backpressure();
        test_idle_ignore();
`ifdef PA_STRIP_EN
        test_strip();
`endif
        test_partial();
        test_reset_midstream();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0;
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
